button_conditioner: RTL and testbench

- Upstream stage of the RGB LED state machine. Turns a raw, bouncing, asynchronous push-button level into clean single-cycle pulses.
- press_pulse drives the LED FSM's In input directly.
- Also produces release_pulse, long_pulse and a debounced level (btn_level) for other consumers.
- Contents: 2-flop synchronizer, debounce state machine, hold timer for long-press detection.

---
 rtl/btn_pkg.sv | 17 +
 rtl/sync_2ff.sv | 28 ++
 rtl/button_conditioner.sv | 152 +++++++++++++++
 tb/tb_button_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioner.
//   btn_state_t : debounce FSM states
//   BTN_*       : default cycle counts and counter width
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned BTN_DEBOUNCE_DEFAULT   = 16;
  localparam int unsigned BTN_LONG_PRESS_DEFAULT = 500;
  localparam int unsigned BTN_CNT_W_DEFAULT      = 10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clock : destination clock
//   reset : synchronous active-high reset, clears both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output, two clock edges behind d_i
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes and debounces a raw button and
// emits single-cycle press / release / long-press pulses.
//   clock         : system clock (rising edge)
//   reset         : synchronous active-high reset
//   btn_raw       : raw, bouncing, asynchronous button level (active high)
//   btn_level     : debounced level, 1 in PRESSED and RELEASE_WAIT
//   press_pulse   : one cycle on an accepted press
//   release_pulse : one cycle on an accepted release
//   long_pulse    : one cycle when a press has been held LONG_PRESS_CYCLES
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEFAULT,
  parameter int unsigned LONG_PRESS_CYCLES = BTN_LONG_PRESS_DEFAULT,
  parameter int unsigned CNT_W             = BTN_CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > ((1 << CNT_W) - 1)) ||
      (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) ||
      (LONG_PRESS_CYCLES > ((1 << CNT_W) - 1))) begin : g_param_check
    $error("button_conditioner: cycle parameters out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] DC_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HC_MAX  = CNT_W'(LONG_PRESS_CYCLES);

  logic btn_sync;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (btn_raw),
    .q_o   (btn_sync)
  );

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] hcnt_inc;
  logic             fired_q, fired_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;
  logic             holding;

  assign hcnt_inc = hcnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    fired_d = fired_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    holding = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (dcnt_q == DC_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
          hcnt_d  = '0;
          fired_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        holding = 1'b1;
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end
      RELEASE_WAIT: begin
        holding = 1'b1;
        if (btn_sync) begin
          state_d = PRESSED;
        end else if (dcnt_q == DC_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = '0;
        hcnt_d  = '0;
        fired_d = 1'b0;
      end
    endcase

    // Hold timer saturates at HC_MAX. A long press that matures on the very
    // edge a release is accepted is dropped so pulses never coincide.
    if (holding && (hcnt_q != HC_MAX)) begin
      hcnt_d = hcnt_inc;
      if ((hcnt_inc == HC_MAX) && !fired_q && (state_d != IDLE)) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end
    end

    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      fired_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      fired_q <= fired_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20): fixed vector table, hand sequences, random bounce.
module tb_button_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned L = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse;

  button_conditioner #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (L),
    .CNT_W             (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  // Reference model: a level flips once the synchronized input (raw delayed
  // two samples) has disagreed with it for D+1 consecutive edges.
  logic m_h0, m_h1;
  logic m_lvl;
  int   m_run, m_age;
  logic m_fired;
  logic e_press, e_rel, e_long;

  logic [3:0] last_got;
  int   cnt_p, cnt_r, cnt_l;
  int   last_pulse;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got(lvl,p,r,l)=%b want=%b", name, cycle, got, exp);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cycle, got, exp);
  endtask

  task automatic model_edge(input logic r, input logic b);
    logic s, prev;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    if (r) begin
      m_h0 = 1'b0; m_h1 = 1'b0; m_lvl = 1'b0;
      m_run = 0; m_age = 0; m_fired = 1'b0;
    end else begin
      s    = m_h1;
      prev = m_lvl;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == int'(D) + 1) begin
          m_lvl = s;
          m_run = 0;
          if (s) begin
            e_press = 1'b1; m_age = 0; m_fired = 1'b0;
          end else begin
            e_rel = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
      if (prev && !e_rel && m_age < int'(L)) begin
        m_age++;
        if (m_age == int'(L) && !m_fired) begin
          e_long = 1'b1; m_fired = 1'b1;
        end
      end
      m_h1 = m_h0;
      m_h0 = b;
    end
  endtask

  task automatic step(input logic r, input logic b);
    reset   = r;
    btn_raw = b;
    @(posedge clock);
    model_edge(r, b);
    #1;
    cycle++;
    last_got = {btn_level, press_pulse, release_pulse, long_pulse};
    check("model", last_got, {m_lvl, e_press, e_rel, e_long});
    if (press_pulse) cnt_p++;
    if (release_pulse) cnt_r++;
    if (long_pulse) cnt_l++;
    if (r) last_pulse = 0;
    if (press_pulse || release_pulse || long_pulse)
      check_int("onehot", 32'(press_pulse) + 32'(release_pulse) + 32'(long_pulse), 1);
    if (press_pulse) begin
      check_int("alt_press", (last_pulse == 1) ? 1 : 0, 0);
      last_pulse = 1;
    end
    if (release_pulse) begin
      check_int("alt_release", last_pulse, 1);
      last_pulse = 2;
    end
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) step(1'b0, b);
  endtask

  typedef struct {
    logic       rst;
    logic       raw;
    logic [3:0] exp;   // {btn_level, press, release, long}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic b, input logic [3:0] e, input int n);
    vec_t v;
    v.rst = r; v.raw = b; v.exp = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    cnt_p = 0; cnt_r = 0; cnt_l = 0; last_pulse = 0;
    m_h0 = 0; m_h1 = 0; m_lvl = 0; m_run = 0; m_age = 0; m_fired = 0;

    // Reset while held, re-debounce, long press, release.
    add(1, 1, 4'b0000, 3);
    add(0, 1, 4'b0000, 6);
    add(0, 1, 4'b1100, 1);
    add(0, 1, 4'b1000, 19);
    add(0, 1, 4'b1001, 1);
    add(0, 1, 4'b1000, 5);
    add(0, 0, 4'b1000, 6);
    add(0, 0, 4'b0010, 1);
    add(0, 0, 4'b0000, 3);
    // Bounce 1,1,0,1,0 rejected.
    add(0, 1, 4'b0000, 2);
    add(0, 0, 4'b0000, 1);
    add(0, 1, 4'b0000, 1);
    add(0, 0, 4'b0000, 8);
    // Drop on the final debounce count: no press.
    add(0, 1, 4'b0000, 4);
    add(0, 0, 4'b0000, 8);
    // One extra sample is enough; release follows six edges after first low.
    add(0, 1, 4'b0000, 5);
    add(0, 0, 4'b0000, 1);
    add(0, 0, 4'b1100, 1);
    add(0, 0, 4'b1000, 4);
    add(0, 0, 4'b0010, 1);
    add(0, 0, 4'b0000, 4);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].raw);
      check("table", last_got, vecs[i].exp);
    end

    // Release glitch while held, then long press, then clean release.
    cnt_p = 0; cnt_r = 0; cnt_l = 0;
    hold(1, 10); hold(0, 2); hold(1, 30); hold(0, 10);
    check_int("glitch_press", cnt_p, 1);
    check_int("glitch_release", cnt_r, 1);
    check_int("glitch_long", cnt_l, 1);

    // Release after 10 held cycles: no long press.
    cnt_p = 0; cnt_r = 0; cnt_l = 0;
    hold(1, 16); hold(0, 12);
    check_int("short_press", cnt_p, 1);
    check_int("short_release", cnt_r, 1);
    check_int("short_long", cnt_l, 0);

    // Reset in the middle of a held press: a second press must re-debounce.
    cnt_p = 0; cnt_r = 0; cnt_l = 0;
    hold(1, 10);
    step(1, 1); step(1, 1);
    hold(1, 6);
    check_int("rst_held_wait", cnt_p, 1);
    hold(1, 1);
    check_int("rst_held_press", cnt_p, 2);
    hold(0, 10);

    // Random bouncy presses of random duration with occasional resets.
    for (int seg = 0; seg < 120; seg++) begin
      logic lvl;
      int   nb, len;
      lvl = seg[0];
      nb  = $urandom_range(0, 4);
      for (int i = 0; i < nb; i++) step(1'b0, 1'($urandom));
      len = $urandom_range(1, 35);
      if ($urandom_range(0, 39) == 0) begin
        step(1'b1, lvl);
        len = len - 1;
      end
      hold(lvl, len);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
